// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: EX forwarding selects, load-use stall, redirect flush, data-memory wait FSM and saturating stall/flush counters
module pipeline_hazard_ctrl #(
  parameter int REG_AW       = 5,
  parameter int DATA_MEM_LAT = 1,
  parameter int CNT_W        = 32
) (
  input  logic              clk,
  input  logic              RESET,
  input  logic [REG_AW-1:0] rs_d,
  input  logic [REG_AW-1:0] rt_d,
  input  logic [REG_AW-1:0] rs_e,
  input  logic [REG_AW-1:0] rt_e,
  input  logic [REG_AW-1:0] write_reg_e,
  input  logic [REG_AW-1:0] write_reg_m,
  input  logic [REG_AW-1:0] write_reg_w,
  input  logic              reg_write_e,
  input  logic              reg_write_m,
  input  logic              reg_write_w,
  input  logic              mem_to_reg_e,
  input  logic              mem_to_reg_m,
  input  logic              mem_access_m,
  input  logic              branch_taken_m,
  input  logic              jump_m,
  output logic [1:0]        forward_a_e,
  output logic [1:0]        forward_b_e,
  output logic              stall_f,
  output logic              stall_d,
  output logic              stall_e,
  output logic              stall_m,
  output logic              flush_d,
  output logic              flush_e,
  output logic              bubble_w,
  output logic              mem_busy,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_count
);
  localparam int CW = $clog2(DATA_MEM_LAT) + 1;
  localparam logic MULTI = DATA_MEM_LAT > 1;
  typedef enum logic {S_IDLE, S_WAIT} state_t;
  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d, flush_count_q, flush_count_d;
  logic             lu, rd, busy, wait_act, rd_app, lu_app, start;
  always_comb begin
    forward_a_e = (reg_write_m && write_reg_m != '0 && write_reg_m == rs_e) ? {1'b1, mem_to_reg_m} :
                  (reg_write_w && write_reg_w != '0 && write_reg_w == rs_e) ? 2'b01 : 2'b00;
    forward_b_e = (reg_write_m && write_reg_m != '0 && write_reg_m == rt_e) ? {1'b1, mem_to_reg_m} :
                  (reg_write_w && write_reg_w != '0 && write_reg_w == rt_e) ? 2'b01 : 2'b00;
    lu       = mem_to_reg_e && reg_write_e && write_reg_e != '0 && (write_reg_e == rs_d || write_reg_e == rt_d);
    rd       = branch_taken_m || jump_m;
    start    = state_q == S_IDLE && mem_access_m && MULTI;
    busy     = state_q == S_WAIT && cnt_q != CW'(1);
    wait_act = busy || start;
    rd_app   = rd && !wait_act;
    lu_app   = lu && !rd && !wait_act;
    stall_f  = wait_act || lu_app;
    stall_d  = wait_act || lu_app;
    stall_e  = wait_act;
    stall_m  = wait_act;
    bubble_w = wait_act;
    mem_busy = busy;
    flush_d  = rd_app;
    flush_e  = rd_app || lu_app;
    state_d  = state_q == S_IDLE ? (start ? S_WAIT : S_IDLE) : (cnt_q == CW'(1) ? S_IDLE : S_WAIT);
    cnt_d    = state_q == S_IDLE ? (start ? CW'(DATA_MEM_LAT - 1) : cnt_q) : cnt_q - CW'(1);
    stall_cycles_d = (stall_f && !(&stall_cycles_q)) ? stall_cycles_q + CNT_W'(1) : stall_cycles_q;
    flush_count_d  = (rd_app && !(&flush_count_q)) ? flush_count_q + CNT_W'(1) : flush_count_q;
  end
  always_ff @(posedge clk) begin
    if (RESET) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end
  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed self-checking bench over three latency/counter-width configurations
module tb_pipeline_hazard_ctrl;
  logic       clk = 0;
  logic       RESET;
  logic [4:0] rs_d, rt_d, rs_e, rt_e, write_reg_e, write_reg_m, write_reg_w;
  logic       reg_write_e, reg_write_m, reg_write_w, mem_to_reg_e, mem_to_reg_m;
  logic       mem_access_m, branch_taken_m, jump_m;
  logic [1:0] fa4, fb4, fa1, fb1, fa3, fb3;
  logic       sf4, sd4, se4, sm4, fd4, fe4, bw4, mb4;
  logic       sf1, sd1, se1, sm1, fd1, fe1, bw1, mb1;
  logic       sf3, sd3, se3, sm3, fd3, fe3, bw3, mb3;
  logic [31:0] sc4, fc4, sc1, fc1;
  logic [3:0]  sc3, fc3;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  pipeline_hazard_ctrl #(.REG_AW(5), .DATA_MEM_LAT(4), .CNT_W(32)) u4 (
    .clk(clk), .RESET(RESET), .rs_d(rs_d), .rt_d(rt_d), .rs_e(rs_e), .rt_e(rt_e),
    .write_reg_e(write_reg_e), .write_reg_m(write_reg_m), .write_reg_w(write_reg_w),
    .reg_write_e(reg_write_e), .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
    .mem_to_reg_e(mem_to_reg_e), .mem_to_reg_m(mem_to_reg_m), .mem_access_m(mem_access_m),
    .branch_taken_m(branch_taken_m), .jump_m(jump_m), .forward_a_e(fa4), .forward_b_e(fb4),
    .stall_f(sf4), .stall_d(sd4), .stall_e(se4), .stall_m(sm4), .flush_d(fd4), .flush_e(fe4),
    .bubble_w(bw4), .mem_busy(mb4), .stall_cycles(sc4), .flush_count(fc4));
  pipeline_hazard_ctrl #(.REG_AW(5), .DATA_MEM_LAT(1), .CNT_W(32)) u1 (
    .clk(clk), .RESET(RESET), .rs_d(rs_d), .rt_d(rt_d), .rs_e(rs_e), .rt_e(rt_e),
    .write_reg_e(write_reg_e), .write_reg_m(write_reg_m), .write_reg_w(write_reg_w),
    .reg_write_e(reg_write_e), .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
    .mem_to_reg_e(mem_to_reg_e), .mem_to_reg_m(mem_to_reg_m), .mem_access_m(mem_access_m),
    .branch_taken_m(branch_taken_m), .jump_m(jump_m), .forward_a_e(fa1), .forward_b_e(fb1),
    .stall_f(sf1), .stall_d(sd1), .stall_e(se1), .stall_m(sm1), .flush_d(fd1), .flush_e(fe1),
    .bubble_w(bw1), .mem_busy(mb1), .stall_cycles(sc1), .flush_count(fc1));
  pipeline_hazard_ctrl #(.REG_AW(5), .DATA_MEM_LAT(3), .CNT_W(4)) u3 (
    .clk(clk), .RESET(RESET), .rs_d(rs_d), .rt_d(rt_d), .rs_e(rs_e), .rt_e(rt_e),
    .write_reg_e(write_reg_e), .write_reg_m(write_reg_m), .write_reg_w(write_reg_w),
    .reg_write_e(reg_write_e), .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
    .mem_to_reg_e(mem_to_reg_e), .mem_to_reg_m(mem_to_reg_m), .mem_access_m(mem_access_m),
    .branch_taken_m(branch_taken_m), .jump_m(jump_m), .forward_a_e(fa3), .forward_b_e(fb3),
    .stall_f(sf3), .stall_d(sd3), .stall_e(se3), .stall_m(sm3), .flush_d(fd3), .flush_e(fe3),
    .bubble_w(bw3), .mem_busy(mb3), .stall_cycles(sc3), .flush_count(fc3));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic clear();
    {rs_d, rt_d, rs_e, rt_e, write_reg_e, write_reg_m, write_reg_w} = '0;
    {reg_write_e, reg_write_m, reg_write_w, mem_to_reg_e, mem_to_reg_m} = '0;
    {mem_access_m, branch_taken_m, jump_m} = '0;
  endtask
  initial begin
    int n_sm4, n_mb4, n_sm3, n_mb3, n_sm1;
    clear();
    RESET = 1;
    tick();
    tick();
    RESET = 0;
    #1;
    check("rst_sc4", sc4, 0);
    check("rst_fc4", fc4, 0);
    check("rst_sc3", 32'(sc3), 0);
    check("rst_busy4", mb4, 0);
    check("rst_stall_f4", sf4, 0);
    write_reg_m = 8; reg_write_m = 1; write_reg_w = 8; reg_write_w = 1; rs_e = 8; rt_e = 8;
    #1 check("fwd_a_mem_alu", fa4, 2'b10);
    mem_to_reg_m = 1;
    #1 check("fwd_a_mem_load", fa4, 2'b11);
    check("fwd_b_mem_load", fb3, 2'b11);
    write_reg_m = 0;
    #1 check("fwd_a_wb", fa4, 2'b01);
    check("fwd_b_wb", fb1, 2'b01);
    rt_e = 9;
    #1 check("fwd_b_none", fb4, 2'b00);
    reg_write_w = 0; write_reg_m = 9;
    #1 check("fwd_b_mem_only", fb4, 2'b11);
    check("fwd_a_none", fa4, 2'b00);
    write_reg_m = 0; write_reg_w = 0; rs_e = 0; reg_write_w = 1;
    #1 check("fwd_a_r0", fa4, 2'b00);
    clear();
    tick();
    mem_to_reg_e = 1; reg_write_e = 1; write_reg_e = 3; rt_d = 3;
    #1 check("lu_stall_f", sf4, 1);
    check("lu_stall_d", sd4, 1);
    check("lu_flush_e", fe4, 1);
    check("lu_flush_d", fd4, 0);
    check("lu_stall_e", se4, 0);
    tick();
    clear();
    check("lu_sc4", sc4, 1);
    check("lu_sc3", 32'(sc3), 1);
    mem_to_reg_e = 1; reg_write_e = 1; write_reg_e = 0; rt_d = 0;
    #1 check("lu_r0_stall_f", sf4, 0);
    tick();
    check("lu_r0_sc4", sc4, 1);
    mem_to_reg_e = 1; reg_write_e = 1; write_reg_e = 3; rs_d = 3; branch_taken_m = 1;
    #1 check("rd_flush_d", fd4, 1);
    check("rd_flush_e", fe4, 1);
    check("rd_stall_f", sf4, 0);
    tick();
    clear();
    check("rd_fc4", fc4, 1);
    check("rd_sc4", sc4, 1);
    n_sm4 = 0; n_mb4 = 0; n_sm3 = 0; n_mb3 = 0; n_sm1 = 0;
    mem_access_m = 1;
    for (int i = 0; i < 8; i++) begin
      #1;
      n_sm4 += int'(sm4); n_mb4 += int'(mb4);
      n_sm3 += int'(sm3); n_mb3 += int'(mb3);
      n_sm1 += int'(sm1) + int'(bw1) + int'(mb1);
      tick();
      mem_access_m = 0;
    end
    check("mw_stall4", n_sm4, 3);
    check("mw_busy4", n_mb4, 2);
    check("mw_stall3", n_sm3, 2);
    check("mw_busy3", n_mb3, 1);
    check("mw_lat1", n_sm1, 0);
    check("mw_sc4", sc4, 4);
    check("mw_sc3", 32'(sc3), 3);
    check("mw_sc1", sc1, 1);
    mem_access_m = 1; jump_m = 1;
    #1 check("wr_c0_stall3", sm3, 1);
    check("wr_c0_flush3", fd3, 0);
    check("wr_c0_flush1", fd1, 1);
    tick();
    #1 check("wr_c1_stall3", sm3, 1);
    check("wr_c1_flush3", fe3, 0);
    tick();
    #1 check("wr_c2_stall3", sm3, 0);
    check("wr_c2_flush_d3", fd3, 1);
    check("wr_c2_flush_e3", fe3, 1);
    tick();
    clear();
    for (int i = 0; i < 4; i++) tick();
    check("wr_fc3", 32'(fc3), 2);
    check("wr_sc3", 32'(sc3), 5);
    mem_access_m = 1;
    tick();
    mem_access_m = 0;
    #1 check("rw_busy_before", mb4, 1);
    RESET = 1;
    tick();
    RESET = 0;
    #1 check("rw_busy_after", mb4, 0);
    check("rw_stall_m", sm4, 0);
    check("rw_sc4", sc4, 0);
    check("rw_fc4", fc4, 0);
    mem_to_reg_e = 1; reg_write_e = 1; write_reg_e = 5; rs_d = 5;
    for (int i = 0; i < 20; i++) tick();
    clear();
    check("sat_sc3", 32'(sc3), 15);
    check("sat_sc4", sc4, 20);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central hazard controller for the 5-stage pipeline (IF/ID/EX/MEM/WB). It replaces the forwarding-only hazard logic.
- Generates operand-forwarding selects for EX, load-use stalls, branch/jump redirect flushes, and a memory-latency stall FSM for multi-cycle data memory.
- Keeps saturating stall/flush performance counters.
- Sits beside the pipeline registers; drives their stall/flush inputs and the EX operand muxes.

Parameters:
- REG_AW, 5, register-address width.
- DATA_MEM_LAT, 1, data-memory access latency in cycles. Must be ≥1; 1 means no wait states.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  pipeline clock.
- RESET  in  1  synchronous active-high reset.
- rs_d, rt_d  in  REG_AW  source registers of the instruction in ID.
- rs_e, rt_e  in  REG_AW  source registers of the instruction in EX.
- write_reg_e, write_reg_m, write_reg_w  in  REG_AW  destination registers in EX/MEM/WB.
- reg_write_e, reg_write_m, reg_write_w  in  1  register-write enables per stage.
- mem_to_reg_e, mem_to_reg_m  in  1  instruction is a load (EX, MEM).
- mem_access_m  in  1  load or store in MEM.
- branch_taken_m  in  1  branch in MEM resolved taken.
- jump_m  in  1  J/JAL/JR in MEM.
- forward_a_e, forward_b_e  out  2  EX operand select: 00 regfile, 01 WB result, 10 MEM ALU result, 11 MEM load data.
- stall_f, stall_d, stall_e, stall_m  out  1  hold the PC and the IF/ID, ID/EX, EX/MEM registers respectively.
- flush_d, flush_e  out  1  bubble the IF/ID and ID/EX registers.
- bubble_w  out  1  insert a bubble into MEM/WB.
- mem_busy  out  1  FSM in WAIT.
- stall_cycles, flush_count  out  CNT_W  performance counters.

Behaviour:
- Forwarding (combinational), per operand, shown for rs_e (rt_e identical):
  - MEM match: reg_write_m and write_reg_m != 0 and write_reg_m == rs_e → 10, or 11 if mem_to_reg_m.
  - Otherwise WB match: same rule against write_reg_w/reg_write_w → 01.
  - Otherwise 00.
  - MEM has priority over WB. Register 0 never forwards.
- Load-use: lu = mem_to_reg_e and reg_write_e and write_reg_e != 0 and (write_reg_e == rs_d or write_reg_e == rt_d).
  - Effect: stall_f = stall_d = flush_e = 1 for that cycle.
  - Exactly one bubble per load-use pair.
- Redirect: rd = branch_taken_m or jump_m.
  - Effect: flush_d = flush_e = 1; stall_f = stall_d = 0 (PC takes the redirect target).
  - rd overrides lu: lu stall is suppressed during a redirect.
- Memory-wait FSM, states IDLE and WAIT, down-counter cnt of width clog2(DATA_MEM_LAT)+1.
  - IDLE → WAIT when mem_access_m and DATA_MEM_LAT > 1. On that clock edge cnt ← DATA_MEM_LAT−1.
  - In IDLE with mem_access_m the cycle is itself a wait cycle: stall_f/d/e/m = 1, bubble_w = 1.
  - WAIT: stall_f/d/e/m = 1, bubble_w = 1, mem_busy = 1; cnt decrements each cycle.
  - When cnt == 1 the next state is IDLE, with stalls released. Total stalled cycles per access = DATA_MEM_LAT−1.
  - mem_access_m is ignored while in WAIT, since the same instruction is held.
  - DATA_MEM_LAT = 1: FSM never leaves IDLE; all wait outputs are 0.
- Priority when events coincide: memory wait > redirect > load-use.
  - During a wait, flush_d/flush_e are 0 and a pending redirect is applied in the first cycle after the wait releases; rd is still asserted because MEM is held.
- Counters:
  - stall_cycles += 1 on every cycle with stall_f = 1.
  - flush_count += 1 on every cycle with a redirect applied.
  - Both saturate at all-ones.
- Reset: synchronous. On RESET = 1 at a clock edge: state IDLE, cnt 0, counters 0.
  - Combinational outputs follow the inputs immediately after reset.
  - Reset mid-WAIT aborts the wait: next cycle is IDLE, no stalls.

Test Plan:
- Forwarding: write_reg_m=8, reg_write_m=1, write_reg_w=8, reg_write_w=1, rs_e=8 → forward_a_e=10; set mem_to_reg_m=1 → 11; write_reg_m=0 → 01; rt_e=9 → forward_b_e=00.
- Load-use: mem_to_reg_e=1, reg_write_e=1, write_reg_e=3, rt_d=3 → stall_f=stall_d=flush_e=1 for one cycle, stall_cycles=1; the same pattern with write_reg_e=0 → no stall.
- Redirect vs load-use: branch_taken_m=1 together with the load-use condition → flush_d=flush_e=1, stall_f=0, flush_count=1, stall_cycles unchanged.
- Memory wait: DATA_MEM_LAT=4, pulse mem_access_m → stall_m=1 for exactly 3 cycles, mem_busy=1 for 2 cycles, then release; with DATA_MEM_LAT=1 → no stalls.
- Wait + redirect: DATA_MEM_LAT=3, mem_access_m=1 and jump_m=1 held → no flush during the 2 stall cycles; flush_d=flush_e=1 in the release cycle.
- Reset/saturation: RESET asserted in WAIT → IDLE next cycle, counters 0; CNT_W=4, 20 stall cycles → stall_cycles=15.
